// File: rtl/fetch_unit.sv
// IF-stage fetch unit: owns the PC, runs the req/ack instruction-memory handshake and
// presents {PC, instruction, valid} to IF/ID, with one skid entry for fetches completed under freeze.
module fetch_unit #(
    parameter int unsigned          WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0]  RESET_PC = '0,
    parameter int unsigned          PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branchTaken,
    input  logic [WORD_LEN-1:0] branchAddr,
    output logic                imemReq,
    output logic [WORD_LEN-1:0] imemAddr,
    input  logic                imemAck,
    input  logic [WORD_LEN-1:0] imemData,
    output logic [WORD_LEN-1:0] PC,
    output logic [WORD_LEN-1:0] instruction,
    output logic                instValid
);

    localparam logic [WORD_LEN-1:0] PcStepW = WORD_LEN'(PC_STEP);

    typedef enum logic [1:0] {StFetch, StHeld, StDrain} state_e;

    state_e              state_q, state_d;
    logic [WORD_LEN-1:0] pc_q, pc_d;
    logic [WORD_LEN-1:0] req_addr_q, req_addr_d;
    logic [WORD_LEN-1:0] skid_pc_q, skid_pc_d;
    logic [WORD_LEN-1:0] skid_inst_q, skid_inst_d;
    logic [WORD_LEN-1:0] out_pc_q, out_pc_d;
    logic [WORD_LEN-1:0] out_inst_q, out_inst_d;
    logic                out_valid_q, out_valid_d;
    // Holds the request low for the first cycle after reset release.
    logic                started_q;
    logic                ack_fire;
    logic [WORD_LEN-1:0] pc_inc;

    assign pc_inc   = pc_q + PcStepW;
    assign ack_fire = imemReq & imemAck;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (branchTaken) begin
            case (state_q)
                StFetch: state_d = (imemReq && !imemAck) ? StDrain : StFetch;
                StDrain: state_d = imemAck ? StFetch : StDrain;
                default: state_d = StFetch;
            endcase
        end else begin
            case (state_q)
                StFetch: if (ack_fire && freeze) state_d = StHeld;
                StHeld:  if (!freeze) state_d = StFetch;
                StDrain: if (imemAck) state_d = StFetch;
                default: state_d = StFetch;
            endcase
        end
    end

    // FSM outputs: a drained request keeps its original address until acked.
    always_comb begin
        imemReq  = started_q && (state_q != StHeld);
        imemAddr = (state_q == StDrain) ? req_addr_q : pc_q;
    end

    // Datapath next-state
    always_comb begin
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_valid_d = out_valid_q;
        if (branchTaken) begin
            pc_d        = branchAddr;
            out_pc_d    = '0;
            out_inst_d  = '0;
            out_valid_d = 1'b0;
            if (state_q == StFetch && imemReq && !imemAck) req_addr_d = pc_q;
        end else begin
            case (state_q)
                StFetch: begin
                    if (ack_fire) begin
                        pc_d = pc_inc;
                        if (!freeze) begin
                            out_pc_d    = pc_inc;
                            out_inst_d  = imemData;
                            out_valid_d = 1'b1;
                        end else begin
                            skid_pc_d   = pc_inc;
                            skid_inst_d = imemData;
                        end
                    end else if (!freeze) begin
                        out_pc_d    = '0;
                        out_inst_d  = '0;
                        out_valid_d = 1'b0;
                    end
                end
                StHeld: begin
                    if (!freeze) begin
                        out_pc_d    = skid_pc_q;
                        out_inst_d  = skid_inst_q;
                        out_valid_d = 1'b1;
                    end
                end
                default: begin
                    if (!freeze) begin
                        out_pc_d    = '0;
                        out_inst_d  = '0;
                        out_valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_addr_q  <= '0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            out_valid_q <= 1'b0;
            started_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_valid_q <= out_valid_d;
            started_q   <= 1'b1;
        end
    end

    assign PC          = out_pc_q;
    assign instruction = out_inst_q;
    assign instValid   = out_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, wait states, freeze/skid, redirects, wrap and reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] branchAddr = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemData = '0;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        instValid;

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .WORD_LEN(32),
        .RESET_PC(32'h0),
        .PC_STEP (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .branchTaken(branchTaken),
        .branchAddr (branchAddr),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemAck    (imemAck),
        .imemData   (imemData),
        .PC         (PC),
        .instruction(instruction),
        .instValid  (instValid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; freeze = 1'b0; branchTaken = 1'b0; imemAck = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    // Zero-wait acks; data tags the address so later checks know what was presented.
    task automatic run_acks(input int n);
        for (int i = 0; i < n; i++) begin
            imemAck = 1'b1;
            imemData = 32'h1000 | imemAddr;
            step();
        end
        imemAck = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        total++; if (PC !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", PC); end
        total++; if (instruction !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h want 0", instruction); end
        total++; if (instValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instValid); end
        total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imemReq); end
        rst = 1'b0;
        #1;
        total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL req_before_edge: got %b want 0", imemReq); end
        step();
        total++; if (imemReq !== 1'b1) begin bad++; $display("FAIL first_req: got %b want 1", imemReq); end
        total++; if (imemAddr !== 32'h0) begin bad++; $display("FAIL first_addr: got %h want 0", imemAddr); end
    endtask

    task automatic test_stream();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            total++; if (imemAddr !== a) begin bad++; $display("FAIL stream_addr%0d: got %h want %h", i, imemAddr, a); end
            imemAck = 1'b1;
            imemData = 32'h1000 + a;
            step();
            total++; if (PC !== a + 32'd4) begin bad++; $display("FAIL stream_pc%0d: got %h want %h", i, PC, a + 32'd4); end
            total++; if (instruction !== 32'h1000 + a) begin bad++; $display("FAIL stream_inst%0d: got %h want %h", i, instruction, 32'h1000 + a); end
            total++; if (instValid !== 1'b1) begin bad++; $display("FAIL stream_valid%0d: got %b want 1", i, instValid); end
        end
        imemAck = 1'b0;
    endtask

    task automatic test_wait_states();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            total++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin bad++; $display("FAIL wait_req%0d: got req=%b addr=%h want 1/0", i, imemReq, imemAddr); end
            imemAck = (i == 2);
            imemData = 32'h2000;
            step();
            if (i < 2) begin
                total++; if (instValid !== 1'b0 || instruction !== 32'h0) begin bad++; $display("FAIL wait_bubble%0d: got v=%b i=%h want 0/0", i, instValid, instruction); end
            end else begin
                total++; if (instValid !== 1'b1 || instruction !== 32'h2000 || PC !== 32'h4) begin bad++; $display("FAIL wait_valid: got v=%b i=%h pc=%h want 1/2000/4", instValid, instruction, PC); end
            end
        end
        imemAck = 1'b0;
    endtask

    task automatic test_freeze_skid();
        do_reset();
        run_acks(4);
        total++; if (imemAddr !== 32'h10) begin bad++; $display("FAIL frz_addr: got %h want 10", imemAddr); end
        freeze = 1'b1; imemAck = 1'b1; imemData = 32'h00A00093;
        step();
        imemAck = 1'b0;
        total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL held_req: got %b want 0", imemReq); end
        total++; if (PC !== 32'h10 || instruction !== 32'h100C || instValid !== 1'b1) begin bad++; $display("FAIL held_out: got pc=%h i=%h v=%b want 10/100c/1", PC, instruction, instValid); end
        step();
        total++; if (PC !== 32'h10 || instruction !== 32'h100C) begin bad++; $display("FAIL held_out2: got pc=%h i=%h want 10/100c", PC, instruction); end
        freeze = 1'b0;
        step();
        total++; if (PC !== 32'h14 || instruction !== 32'h00A00093 || instValid !== 1'b1) begin bad++; $display("FAIL skid_out: got pc=%h i=%h v=%b want 14/00a00093/1", PC, instruction, instValid); end
        total++; if (imemReq !== 1'b1 || imemAddr !== 32'h14) begin bad++; $display("FAIL after_skid_req: got req=%b addr=%h want 1/14", imemReq, imemAddr); end
    endtask

    task automatic test_branch_drain();
        do_reset();
        run_acks(8);
        total++; if (imemAddr !== 32'h20) begin bad++; $display("FAIL drain_pre_addr: got %h want 20", imemAddr); end
        branchTaken = 1'b1; branchAddr = 32'h200;
        step();
        branchTaken = 1'b0;
        total++; if (instValid !== 1'b0 || instruction !== 32'h0 || PC !== 32'h0) begin bad++; $display("FAIL drain_bubble: got v=%b i=%h pc=%h want 0/0/0", instValid, instruction, PC); end
        total++; if (imemReq !== 1'b1 || imemAddr !== 32'h20) begin bad++; $display("FAIL drain_hold: got req=%b addr=%h want 1/20", imemReq, imemAddr); end
        step();
        total++; if (imemAddr !== 32'h20) begin bad++; $display("FAIL drain_hold2: got %h want 20", imemAddr); end
        imemAck = 1'b1; imemData = 32'hDEADBEEF;
        step();
        total++; if (instValid !== 1'b0 || instruction !== 32'h0) begin bad++; $display("FAIL drain_drop: got v=%b i=%h want 0/0", instValid, instruction); end
        total++; if (imemReq !== 1'b1 || imemAddr !== 32'h200) begin bad++; $display("FAIL drain_next: got req=%b addr=%h want 1/200", imemReq, imemAddr); end
        imemData = 32'h1200;
        step();
        imemAck = 1'b0;
        total++; if (PC !== 32'h204 || instruction !== 32'h1200 || instValid !== 1'b1) begin bad++; $display("FAIL drain_target: got pc=%h i=%h v=%b want 204/1200/1", PC, instruction, instValid); end
    endtask

    task automatic test_branch_held();
        do_reset();
        run_acks(1);
        freeze = 1'b1; imemAck = 1'b1; imemData = 32'h5555;
        step();
        imemAck = 1'b0;
        total++; if (imemReq !== 1'b0 || PC !== 32'h4) begin bad++; $display("FAIL bh_held: got req=%b pc=%h want 0/4", imemReq, PC); end
        branchTaken = 1'b1; branchAddr = 32'h300;
        step();
        branchTaken = 1'b0;
        total++; if (instValid !== 1'b0 || instruction !== 32'h0 || PC !== 32'h0) begin bad++; $display("FAIL bh_bubble: got v=%b i=%h pc=%h want 0/0/0", instValid, instruction, PC); end
        total++; if (imemReq !== 1'b1 || imemAddr !== 32'h300) begin bad++; $display("FAIL bh_req: got req=%b addr=%h want 1/300", imemReq, imemAddr); end
        freeze = 1'b0; imemAck = 1'b1; imemData = 32'h1300;
        step();
        imemAck = 1'b0;
        total++; if (PC !== 32'h304 || instruction !== 32'h1300 || instValid !== 1'b1) begin bad++; $display("FAIL bh_target: got pc=%h i=%h v=%b want 304/1300/1", PC, instruction, instValid); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        branchTaken = 1'b1; branchAddr = 32'hFFFF_FFFC; imemAck = 1'b1; imemData = 32'h0BAD;
        step();
        branchTaken = 1'b0; imemAck = 1'b0;
        total++; if (imemAddr !== 32'hFFFF_FFFC || instValid !== 1'b0) begin bad++; $display("FAIL wrap_pre: got addr=%h v=%b want fffffffc/0", imemAddr, instValid); end
        imemAck = 1'b1; imemData = 32'h0ABC;
        step();
        imemAck = 1'b0;
        total++; if (PC !== 32'h0 || instruction !== 32'h0ABC || instValid !== 1'b1) begin bad++; $display("FAIL wrap_out: got pc=%h i=%h v=%b want 0/abc/1", PC, instruction, instValid); end
        total++; if (imemAddr !== 32'h0) begin bad++; $display("FAIL wrap_addr: got %h want 0", imemAddr); end
        branchTaken = 1'b1; branchAddr = 32'h40;
        step();
        branchTaken = 1'b0;
        total++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin bad++; $display("FAIL rst_pre_drain: got req=%b addr=%h want 1/0", imemReq, imemAddr); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL rst_async_req: got %b want 0", imemReq); end
        total++; if (PC !== 32'h0 || instruction !== 32'h0 || instValid !== 1'b0) begin bad++; $display("FAIL rst_async_out: got pc=%h i=%h v=%b want 0/0/0", PC, instruction, instValid); end
        step();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait_states();
        test_freeze_skid();
        test_branch_drain();
        test_branch_held();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
